axi4_mem_responder: RTL
=======================

AXI4_MEM_RESPONDER -- requirements
Module: axi4_mem_responder

Interface
REQ-001 SHALL have parameter AXI_LEN_W, default 8: width of the ar/aw len fields (beats = len+1).
REQ-002 SHALL have parameter DW, default 32: data width; WSTRB_W = DW/8.
REQ-003 SHALL have parameter AW, default 32: byte address width.
REQ-004 SHALL have parameter MEM_WORDS, default 4096: backing store depth in DW words, a power of two.
REQ-005 SHALL have parameter STALL_EN, default 0: when 1, ready outputs are throttled pseudo-randomly.
REQ-006 SHALL have ports, in this order: clk in 1, the single clock. rst in 1, synchronous active-high reset.
REQ-007 SHALL have AR ports: axi4_ar_ready out 1; axi4_ar_addr in AW; axi4_ar_valid in 1; axi4_ar_len in AXI_LEN_W.
REQ-008 SHALL have R ports: axi4_r_last out 1; axi4_r_valid out 1; axi4_r_data out DW; axi4_r_ready in 1.
REQ-009 SHALL have AW ports: axi4_aw_ready out 1; axi4_aw_addr in AW; axi4_aw_valid in 1; axi4_aw_len in AXI_LEN_W.
REQ-010 SHALL have W ports: axi4_w_ready out 1; axi4_w_data in DW; axi4_w_strb in WSTRB_W; axi4_w_valid in 1; axi4_w_last in 1.
REQ-011 SHALL have B ports: axi4_b_valid out 1; axi4_b_resp out 1; axi4_b_ready in 1.
REQ-012 SHALL have port protocol_err out 1: sticky w_last mismatch flag.

Function
REQ-013 SHALL implement AXI4 INCR bursts of DW-wide beats; word index = addr[log2(DW/8) +: log2(MEM_WORDS)]; low byte bits and high bits ignored; index wraps modulo MEM_WORDS within a burst.
REQ-014 SHALL run the write FSM WR_IDLE -> WR_DATA -> WR_RESP -> WR_IDLE, independent of the read FSM.
REQ-015 SHALL assert aw_ready only in WR_IDLE; an aw handshake latches address and len, clears the beat counter, and enters WR_DATA.
REQ-016 SHALL assert w_ready only in WR_DATA; each w handshake writes bytes whose strb bit is 1, then increments the word index and beat counter.
REQ-017 SHALL end the burst on the beat where the counter equals len, regardless of w_last, and move to WR_RESP.
REQ-018 SHALL set protocol_err if w_last differs from (counter == len) on any w handshake.
REQ-019 SHALL in WR_RESP hold b_valid=1 and b_resp=0 until b_ready, then return to WR_IDLE; aw is not accepted before that cycle ends.
REQ-020 SHALL run the read FSM RD_IDLE -> RD_FETCH -> RD_DATA -> RD_IDLE.
REQ-021 SHALL assert ar_ready only in RD_IDLE; an ar handshake latches address and len and enters RD_FETCH.
REQ-022 SHALL in RD_FETCH issue a registered memory read and enter RD_DATA the next cycle; first r_valid comes 2 cycles after the ar handshake.
REQ-023 SHALL in RD_DATA hold r_valid=1 and stable r_data/r_last until r_ready.
REQ-024 SHALL on a non-final r handshake read the next word in that cycle, keeping r_valid high for full throughput (1 beat/cycle).
REQ-025 SHALL assert r_last only on beat len; its handshake returns the FSM to RD_IDLE.
REQ-026 SHALL, when a read and a write hit the same word in the same cycle, return the old data to the read.
REQ-027 SHALL, when STALL_EN=1, gate ar_ready, aw_ready and w_ready with separate bits of a 16-bit LFSR (seed 16'hACE1, stepped every cycle); r_valid and b_valid are never gated.
REQ-028 SHALL never drop a beat or deassert a valid output before its handshake.

Reset
REQ-029 SHALL on rst clear both FSMs to IDLE, clear counters, reseed the LFSR, and drive r_valid=0, r_last=0, b_valid=0, b_resp=0, protocol_err=0, and all readies 0 in the reset cycle.
REQ-030 SHALL on a reset mid-burst abandon the burst; memory keeps beats already written, and r_data is don't-care.

Structure
REQ-031 SHALL place the wr_state_t/rd_state_t enums and the LFSR seed constant in mru_pkg.
REQ-032 SHALL implement the backing store as one sub-module, axi_resp_ram: simple dual-port, byte-write, registered read, no reset.

Verification
REQ-033 SHALL cover: aw addr=0x100 len=7, 8 beats data=i, strb=F -> one b_valid, resp=0; ar addr=0x100 len=7 -> r_data 0..7, r_last on beat 7, first r_valid 2 cycles after ar.
REQ-034 SHALL cover: write 0xFFFFFFFF, then strb=4'b0101 data 0x00000000 -> readback 0xFF00FF00.
REQ-035 SHALL cover: r_ready toggling 1010... during an 8-beat read -> data in order, r_valid never drops mid-burst.
REQ-036 SHALL cover: w_last asserted on beat 2 of a len=3 burst -> protocol_err=1, burst still ends after beat 3 with one response.
REQ-037 SHALL cover: write at word MEM_WORDS-2 with len=3 -> words MEM_WORDS-2, MEM_WORDS-1, 0, 1 written.
REQ-038 SHALL cover: STALL_EN=1, 100 random overlapping read/write bursts checked against a scoreboard -> no mismatch; rst mid-read -> r_valid=0 next cycle.

Source files
------------

// File: rtl/mru_pkg.sv
// Shared types and constants for the AXI4 memory responder.
package mru_pkg;

  typedef enum logic [1:0] {
    WR_IDLE,
    WR_DATA,
    WR_RESP
  } wr_state_t;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_FETCH,
    RD_DATA
  } rd_state_t;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // Maximal-length Fibonacci LFSR, taps 16/14/13/11.
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/axi_resp_ram.sv
// Simple dual-port byte-write RAM with registered read; a same-cycle
// read of a word being written returns the old contents.
module axi_resp_ram #(
  parameter int DW    = 32,
  parameter int DEPTH = 4096,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic [IDX_W-1:0] wr_idx_i,
  input  logic [DW-1:0]    wr_data_i,
  input  logic [DW/8-1:0]  wr_strb_i,
  input  logic             rd_en_i,
  input  logic [IDX_W-1:0] rd_idx_i,
  output logic [DW-1:0]    rd_data_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rd_data_q;

  always_ff @(posedge clk_i) begin
    for (int b = 0; b < DW / 8; b++) begin
      if (wr_en_i && wr_strb_i[b]) begin
        mem_q[wr_idx_i][b*8 +: 8] <= wr_data_i[b*8 +: 8];
      end
    end
    if (rd_en_i) begin
      rd_data_q <= mem_q[rd_idx_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axi4_mem_responder.sv
// AXI4 INCR-burst memory slave with independent read and write engines
// and optional pseudo-random ready throttling.
module axi4_mem_responder
  import mru_pkg::*;
#(
  parameter int AXI_LEN_W = 8,
  parameter int DW        = 32,
  parameter int AW        = 32,
  parameter int MEM_WORDS = 4096,
  parameter int STALL_EN  = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  output logic                 axi4_ar_ready,
  input  logic [AW-1:0]        axi4_ar_addr,
  input  logic                 axi4_ar_valid,
  input  logic [AXI_LEN_W-1:0] axi4_ar_len,
  output logic                 axi4_r_last,
  output logic                 axi4_r_valid,
  output logic [DW-1:0]        axi4_r_data,
  input  logic                 axi4_r_ready,
  output logic                 axi4_aw_ready,
  input  logic [AW-1:0]        axi4_aw_addr,
  input  logic                 axi4_aw_valid,
  input  logic [AXI_LEN_W-1:0] axi4_aw_len,
  output logic                 axi4_w_ready,
  input  logic [DW-1:0]        axi4_w_data,
  input  logic [DW/8-1:0]      axi4_w_strb,
  input  logic                 axi4_w_valid,
  input  logic                 axi4_w_last,
  output logic                 axi4_b_valid,
  output logic                 axi4_b_resp,
  input  logic                 axi4_b_ready,
  output logic                 protocol_err
);

  localparam int WSTRB_W = DW / 8;
  localparam int OFF_W   = $clog2(WSTRB_W);
  localparam int IDX_W   = $clog2(MEM_WORDS);

  wr_state_t            wr_state_q, wr_state_d;
  logic [IDX_W-1:0]     wr_idx_q, wr_idx_d;
  logic [AXI_LEN_W-1:0] wr_len_q, wr_len_d, wr_cnt_q, wr_cnt_d;
  logic                 err_q, err_d;
  rd_state_t            rd_state_q, rd_state_d;
  logic [IDX_W-1:0]     rd_idx_q, rd_idx_d;
  logic [AXI_LEN_W-1:0] rd_len_q, rd_len_d, rd_cnt_q, rd_cnt_d;
  logic [15:0]          lfsr_q;
  logic                 ar_gate, aw_gate, w_gate;
  logic                 mem_we, mem_re, wr_beat_last, rd_beat_last;
  logic                 unused_addr;

  assign unused_addr  = ^{axi4_ar_addr, axi4_aw_addr};
  assign ar_gate      = (STALL_EN == 0) || lfsr_q[0];
  assign aw_gate      = (STALL_EN == 0) || lfsr_q[1];
  assign w_gate       = (STALL_EN == 0) || lfsr_q[2];
  assign wr_beat_last = (wr_cnt_q == wr_len_q);
  assign rd_beat_last = (rd_cnt_q == rd_len_q);
  assign axi4_b_resp  = 1'b0;
  assign protocol_err = err_q && !rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state_q <= WR_IDLE;
      wr_idx_q   <= '0;
      wr_len_q   <= '0;
      wr_cnt_q   <= '0;
      err_q      <= 1'b0;
      rd_state_q <= RD_IDLE;
      rd_idx_q   <= '0;
      rd_len_q   <= '0;
      rd_cnt_q   <= '0;
      lfsr_q     <= LFSR_SEED;
    end else begin
      wr_state_q <= wr_state_d;
      wr_idx_q   <= wr_idx_d;
      wr_len_q   <= wr_len_d;
      wr_cnt_q   <= wr_cnt_d;
      err_q      <= err_d;
      rd_state_q <= rd_state_d;
      rd_idx_q   <= rd_idx_d;
      rd_len_q   <= rd_len_d;
      rd_cnt_q   <= rd_cnt_d;
      lfsr_q     <= lfsr_next(lfsr_q);
    end
  end

  // Outputs are forced low during the reset cycle regardless of stale state.
  always_comb begin
    wr_state_d    = wr_state_q;
    wr_idx_d      = wr_idx_q;
    wr_len_d      = wr_len_q;
    wr_cnt_d      = wr_cnt_q;
    err_d         = err_q;
    axi4_aw_ready = 1'b0;
    axi4_w_ready  = 1'b0;
    axi4_b_valid  = 1'b0;
    mem_we        = 1'b0;
    if (!rst) begin
      case (wr_state_q)
        WR_IDLE: begin
          axi4_aw_ready = aw_gate;
          if (axi4_aw_valid && aw_gate) begin
            wr_idx_d   = axi4_aw_addr[OFF_W +: IDX_W];
            wr_len_d   = axi4_aw_len;
            wr_cnt_d   = '0;
            wr_state_d = WR_DATA;
          end
        end
        WR_DATA: begin
          axi4_w_ready = w_gate;
          if (axi4_w_valid && w_gate) begin
            mem_we   = 1'b1;
            wr_idx_d = wr_idx_q + 1'b1;
            wr_cnt_d = wr_cnt_q + 1'b1;
            if (axi4_w_last != wr_beat_last) err_d = 1'b1;
            if (wr_beat_last) wr_state_d = WR_RESP;
          end
        end
        WR_RESP: begin
          axi4_b_valid = 1'b1;
          if (axi4_b_ready) wr_state_d = WR_IDLE;
        end
        default: wr_state_d = WR_IDLE;
      endcase
    end
  end

  // The RAM is addressed with rd_idx_d so the next beat is fetched in the
  // same cycle as the current beat's handshake.
  always_comb begin
    rd_state_d    = rd_state_q;
    rd_idx_d      = rd_idx_q;
    rd_len_d      = rd_len_q;
    rd_cnt_d      = rd_cnt_q;
    axi4_ar_ready = 1'b0;
    axi4_r_valid  = 1'b0;
    axi4_r_last   = 1'b0;
    mem_re        = 1'b0;
    if (!rst) begin
      case (rd_state_q)
        RD_IDLE: begin
          axi4_ar_ready = ar_gate;
          if (axi4_ar_valid && ar_gate) begin
            rd_idx_d   = axi4_ar_addr[OFF_W +: IDX_W];
            rd_len_d   = axi4_ar_len;
            rd_cnt_d   = '0;
            rd_state_d = RD_FETCH;
          end
        end
        RD_FETCH: begin
          mem_re     = 1'b1;
          rd_state_d = RD_DATA;
        end
        RD_DATA: begin
          axi4_r_valid = 1'b1;
          axi4_r_last  = rd_beat_last;
          if (axi4_r_ready) begin
            if (rd_beat_last) begin
              rd_state_d = RD_IDLE;
            end else begin
              rd_idx_d = rd_idx_q + 1'b1;
              rd_cnt_d = rd_cnt_q + 1'b1;
              mem_re   = 1'b1;
            end
          end
        end
        default: rd_state_d = RD_IDLE;
      endcase
    end
  end

  axi_resp_ram #(
    .DW    (DW),
    .DEPTH (MEM_WORDS)
  ) u_ram (
    .clk_i     (clk),
    .wr_en_i   (mem_we),
    .wr_idx_i  (wr_idx_q),
    .wr_data_i (axi4_w_data),
    .wr_strb_i (axi4_w_strb),
    .rd_en_i   (mem_re),
    .rd_idx_i  (rd_idx_d),
    .rd_data_o (axi4_r_data)
  );

endmodule
